// File: rtl/gc_poll_sequencer.sv
// GameCube poll sequencer: periodic poll starts, timeout supervision, frame
// validation and lock-aware commit of the 81-bit frame to the stick datapath.
module gc_poll_sequencer #(
    parameter logic [15:0] POLL_INTERVAL = 16'd20000,
    parameter logic [15:0] TIMEOUT_CYC   = 16'd8000,
    parameter logic [3:0]  MAX_FAIL      = 4'd3,
    parameter logic [7:0]  NEUTRAL       = 8'd129
) (
    input  logic        clk,
    input  logic        reset,
    output logic        gc_start,
    input  logic        gc_done,
    input  logic        gc_err,
    input  logic [80:0] gc_data,
    input  logic        n64_lock,
    output logic [80:0] data,
    output logic        analog_check,
    output logic        link_ok,
    output logic [7:0]  fail_count
);

    localparam logic [80:0] NEUTRAL_FRAME = {17'd0, NEUTRAL, NEUTRAL, NEUTRAL, NEUTRAL, 32'd0};

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_CHECK,
        S_HOLD,
        S_COMMIT
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [80:0] pend_data_q, pend_data_d;
    logic        pend_err_q, pend_err_d;
    logic        pend_neutral_q, pend_neutral_d;
    logic [80:0] data_q, data_d;
    logic        ac_q, ac_d;
    logic        link_q, link_d;
    logic [7:0]  fail_q, fail_d;
    logic [3:0]  consec_q, consec_d;
    logic        fail_evt;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    function automatic logic [3:0] consec_inc(input logic [3:0] v);
        return (v >= MAX_FAIL) ? MAX_FAIL : v + 4'd1;
    endfunction

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        pend_data_d    = pend_data_q;
        pend_err_d     = pend_err_q;
        pend_neutral_d = pend_neutral_q;
        data_d         = data_q;
        ac_d           = 1'b0;
        link_d         = link_q;
        fail_d         = fail_q;
        consec_d       = consec_q;
        gc_start       = 1'b0;
        fail_evt       = 1'b0;

        // one counter serves as the poll interval in IDLE and the timeout in WAIT
        case (state_q)
            S_IDLE: begin
                if (cnt_q >= POLL_INTERVAL - 16'd1) begin
                    state_d = S_START;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_START: begin
                gc_start = 1'b1;
                cnt_d    = '0;
                state_d  = S_WAIT;
            end
            S_WAIT: begin
                if (gc_done) begin
                    pend_data_d    = gc_data;
                    pend_err_d     = gc_err;
                    pend_neutral_d = 1'b0;
                    state_d        = S_CHECK;
                end else if (cnt_q >= TIMEOUT_CYC - 16'd1) begin
                    fail_evt = 1'b1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_CHECK: begin
                if (!pend_err_q && pend_data_q[0]) begin
                    consec_d = '0;
                    state_d  = S_HOLD;
                end else begin
                    fail_evt = 1'b1;
                end
            end
            S_HOLD: begin
                if (!n64_lock) begin
                    state_d = S_COMMIT;
                end
            end
            S_COMMIT: begin
                data_d  = pend_data_q;
                ac_d    = 1'b1;
                if (!pend_neutral_q) begin
                    link_d = 1'b1;
                end
                state_d = S_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        if (fail_evt) begin
            fail_d   = sat_inc8(fail_q);
            consec_d = consec_inc(consec_q);
            cnt_d    = '0;
            // a dead link still gets a centred stick pushed through the normal commit path
            if (consec_d >= MAX_FAIL) begin
                pend_data_d    = NEUTRAL_FRAME;
                pend_neutral_d = 1'b1;
                link_d         = 1'b0;
                state_d        = S_HOLD;
            end else begin
                state_d = S_IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            data_q   <= NEUTRAL_FRAME;
            ac_q     <= 1'b0;
            link_q   <= 1'b0;
            fail_q   <= '0;
            consec_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            data_q   <= data_d;
            ac_q     <= ac_d;
            link_q   <= link_d;
            fail_q   <= fail_d;
            consec_q <= consec_d;
        end
    end

    always_ff @(posedge clk) begin
        pend_data_q    <= pend_data_d;
        pend_err_q     <= pend_err_d;
        pend_neutral_q <= pend_neutral_d;
    end

    assign data         = data_q;
    assign analog_check = ac_q;
    assign link_ok      = link_q;
    assign fail_count   = fail_q;

endmodule

// File: tb/tb_gc_poll_sequencer.sv
// Randomised bench for gc_poll_sequencer: transaction-level model predicts poll
// start cycles, commit cycles and output values; outputs are compared every cycle.
module tb_gc_poll_sequencer;

    localparam int P    = 50;
    localparam int T    = 110;
    localparam int MAXF = 3;
    localparam logic [7:0]  NB = 8'd129;
    localparam logic [80:0] NEUTRAL_FRAME = {17'd0, NB, NB, NB, NB, 32'd0};

    localparam int K_VALID = 0;
    localparam int K_ERR   = 1;
    localparam int K_STOP  = 2;
    localparam int K_TO    = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        gc_start;
    logic        gc_done = 1'b0;
    logic        gc_err = 1'b0;
    logic [80:0] gc_data = '0;
    logic        n64_lock = 1'b0;
    logic [80:0] data;
    logic        analog_check;
    logic        link_ok;
    logic [7:0]  fail_count;

    gc_poll_sequencer #(
        .POLL_INTERVAL(16'(P)),
        .TIMEOUT_CYC  (16'(T)),
        .MAX_FAIL     (4'(MAXF)),
        .NEUTRAL      (NB)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .gc_start    (gc_start),
        .gc_done     (gc_done),
        .gc_err      (gc_err),
        .gc_data     (gc_data),
        .n64_lock    (n64_lock),
        .data        (data),
        .analog_check(analog_check),
        .link_ok     (link_ok),
        .fail_count  (fail_count)
    );

    always #5 clk = ~clk;

    // cycle 1 is the first cycle after reset has been sampled
    int cyc = 0;
    always @(posedge clk) cyc <= reset ? 1 : cyc + 1;

    int checks = 0;
    int failures = 0;

    // model: base values plus at most one scheduled change per output
    logic [80:0] base_data;
    logic        base_link;
    int          base_fail;
    int          upd_data_cyc = -1;
    logic [80:0] upd_data_val;
    int          upd_link_cyc = -1;
    logic        upd_link_val;
    int          upd_fail_cyc = -1;
    int          upd_fail_val;
    int          model_fails;
    int          model_consec;
    int          exp_start = -1;
    int          exp_ac = -1;

    int last_start_cyc = -1;
    int last_ac_cyc = -1;
    int ac_total = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [80:0] exp_data_f(input int c);
        return (upd_data_cyc != -1 && c >= upd_data_cyc) ? upd_data_val : base_data;
    endfunction

    function automatic logic exp_link_f(input int c);
        return (upd_link_cyc != -1 && c >= upd_link_cyc) ? upd_link_val : base_link;
    endfunction

    function automatic int exp_fail_f(input int c);
        return (upd_fail_cyc != -1 && c >= upd_fail_cyc) ? upd_fail_val : base_fail;
    endfunction

    always @(negedge clk) begin
        if (!reset) begin
            chk("gc_start", 128'(gc_start), 128'(cyc == exp_start));
            chk("analog_check", 128'(analog_check), 128'(cyc == exp_ac));
            chk("data", 128'(data), 128'(exp_data_f(cyc)));
            chk("link_ok", 128'(link_ok), 128'(exp_link_f(cyc)));
            chk("fail_count", 128'(fail_count), 128'(exp_fail_f(cyc)));
            if (gc_start) last_start_cyc <= cyc;
            if (analog_check) begin
                last_ac_cyc <= cyc;
                ac_total    <= ac_total + 1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [80:0] rnd_frame();
        logic [95:0] r;
        r = {$urandom, $urandom, $urandom};
        return r[80:0];
    endfunction

    task automatic model_reset();
        base_data    = NEUTRAL_FRAME;
        base_link    = 1'b0;
        base_fail    = 0;
        upd_data_cyc = -1;
        upd_link_cyc = -1;
        upd_fail_cyc = -1;
        model_fails  = 0;
        model_consec = 0;
        exp_start    = P + 1;
        exp_ac       = -1;
    endtask

    task automatic fold_updates();
        if (upd_data_cyc != -1) begin base_data = upd_data_val; upd_data_cyc = -1; end
        if (upd_link_cyc != -1) begin base_link = upd_link_val; upd_link_cyc = -1; end
        if (upd_fail_cyc != -1) begin base_fail = upd_fail_val; upd_fail_cyc = -1; end
    endtask

    task automatic do_reset(input int cycles);
        reset   = 1'b1;
        gc_done = 1'b0;
        repeat (cycles) tick();
        model_reset();
        reset = 1'b0;
    endtask

    // One poll transaction. d = start-to-done distance; len = cycles of n64_lock from the done cycle.
    task automatic txn(input int kind, input int d, input int len, input logic [80:0] frame);
        int s, c, f, hold_end, ac, end_c;
        logic [80:0] fr;
        logic err;
        fold_updates();
        s   = exp_start;
        c   = (kind == K_TO) ? s + T - 1 : s + d;
        fr  = frame;
        err = 1'b0;
        if (kind == K_VALID) fr[0] = 1'b1;
        else if (kind == K_STOP) fr[0] = 1'b0;
        else if (kind == K_ERR) err = 1'b1;

        while (cyc < c) begin
            gc_done  = (cyc <= s) && ($urandom_range(0, 15) == 0);
            gc_err   = 1'(($urandom_range(0, 1)));
            gc_data  = rnd_frame();
            n64_lock = ($urandom_range(0, 3) == 0);
            tick();
        end

        hold_end = (c + len > c + 2) ? c + len : c + 2;
        ac = -1;
        if (kind == K_VALID) begin
            model_consec = 0;
            ac = hold_end + 2;
            upd_data_cyc = ac; upd_data_val = fr;
            upd_link_cyc = ac; upd_link_val = 1'b1;
            exp_start = ac + P;
        end else begin
            f = c + 1;
            model_fails = model_fails + 1;
            upd_fail_cyc = f + 1;
            upd_fail_val = (model_fails > 255) ? 255 : model_fails;
            model_consec = (model_consec + 1 > MAXF) ? MAXF : model_consec + 1;
            if (model_consec == MAXF) begin
                ac = hold_end + 2;
                upd_data_cyc = ac; upd_data_val = NEUTRAL_FRAME;
                upd_link_cyc = f + 1; upd_link_val = 1'b0;
                exp_start = ac + P;
            end else begin
                exp_start = f + 1 + P;
            end
        end
        exp_ac = ac;

        gc_done  = (kind != K_TO);
        gc_err   = err;
        gc_data  = fr;
        n64_lock = (len > 0);
        end_c = (ac > c + 3) ? ac : c + 3;
        if (c + len > end_c) end_c = c + len;
        end_c = end_c + 1;
        while (cyc < end_c) begin
            tick();
            gc_done  = (kind == K_TO) && (cyc == c + 2);
            gc_err   = gc_done ? 1'b0 : 1'(($urandom_range(0, 1)));
            gc_data  = rnd_frame() | 81'd1;
            n64_lock = (cyc < c + len);
        end
        gc_done  = 1'b0;
        n64_lock = 1'b0;
    endtask

    initial begin
        #2000000;
        failures++;
        $display("FAIL watchdog cycle=%0d got=timeout expected=finish", cyc);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [80:0] fr0;
        int kind, d, len;

        model_reset();
        do_reset(3);
        chk("rst_data", 128'(data), 128'({17'd0, 8'd129, 8'd129, 8'd129, 8'd129, 32'd0}));
        chk("rst_link", 128'(link_ok), 128'(0));
        chk("rst_fail", 128'(fail_count), 128'(0));
        chk("rst_ac", 128'(analog_check), 128'(0));

        // first poll at P+1 = 51, done at 151, strobe once CHECK/HOLD/COMMIT have passed
        fr0 = NEUTRAL_FRAME;
        fr0[63:56] = 8'h80;
        fr0[0] = 1'b1;
        txn(K_VALID, 100, 0, fr0);
        chk("t1_first_start", 128'(last_start_cyc), 128'(51));
        chk("t1_ac_cycle", 128'(last_ac_cyc), 128'(155));
        chk("t1_data", 128'(data), 128'({17'd0, 8'h80, 8'd129, 8'd129, 8'd129, 31'd0, 1'b1}));
        chk("t1_link", 128'(link_ok), 128'(1));
        chk("t1_ac_total", 128'(ac_total), 128'(1));

        // start 205, done 305, lock 305..354, falls at 355, strobe at 357
        txn(K_VALID, 100, 50, rnd_frame());
        chk("t2_start", 128'(last_start_cyc), 128'(205));
        chk("t2_ac_cycle", 128'(last_ac_cyc), 128'(357));

        // timeouts expire at 516, 677, 838; the third commits neutral at 842
        repeat (3) txn(K_TO, 0, 0, '0);
        chk("t3_fail", 128'(fail_count), 128'(3));
        chk("t3_link", 128'(link_ok), 128'(0));
        chk("t3_data", 128'(data), 128'({17'd0, 8'd129, 8'd129, 8'd129, 8'd129, 32'd0}));
        chk("t3_ac_cycle", 128'(last_ac_cyc), 128'(842));
        chk("t3_ac_total", 128'(ac_total), 128'(3));

        txn(K_VALID, 20, 0, rnd_frame());
        txn(K_ERR, 30, 0, rnd_frame());
        chk("t4_fail", 128'(fail_count), 128'(4));
        chk("t4_link", 128'(link_ok), 128'(1));
        chk("t4_ac_total", 128'(ac_total), 128'(4));
        txn(K_VALID, 40, 0, rnd_frame());
        chk("t4_ac_total2", 128'(ac_total), 128'(5));

        // boundary: done in the very cycle the timeout expires
        txn(K_VALID, T, 0, rnd_frame());
        txn(K_STOP, 5, 0, rnd_frame());

        for (int i = 0; i < 80; i++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4: kind = K_VALID;
                5, 6:          kind = K_ERR;
                7:             kind = K_STOP;
                default:       kind = K_TO;
            endcase
            d = ($urandom_range(0, 7) == 0) ? T : $urandom_range(1, T);
            len = ($urandom_range(0, 3) == 0) ? $urandom_range(3, 40) : $urandom_range(0, 2);
            txn(kind, d, len, rnd_frame());
        end

        for (int i = 0; i < 260; i++) begin
            txn(K_ERR, 1, 0, rnd_frame());
        end
        chk("sat_fail", 128'(fail_count), 128'(255));
        chk("sat_link", 128'(link_ok), 128'(0));

        // reset in the middle of WAIT, then a stray done in IDLE
        fold_updates();
        while (cyc < exp_start + 5) tick();
        do_reset(2);
        while (cyc < 3) tick();
        gc_done = 1'b1;
        gc_err  = 1'b0;
        gc_data = rnd_frame() | 81'd1;
        tick();
        gc_done = 1'b0;
        while (cyc < 20) tick();
        chk("rw_data", 128'(data), 128'({17'd0, 8'd129, 8'd129, 8'd129, 8'd129, 32'd0}));
        chk("rw_fail", 128'(fail_count), 128'(0));
        chk("rw_link", 128'(link_ok), 128'(0));
        txn(K_VALID, 10, 0, rnd_frame());
        chk("rw_start", 128'(last_start_cyc), 128'(51));
        chk("rw_link2", 128'(link_ok), 128'(1));

        repeat (3) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
